cardinal_nic_fifo: RTL

//  Queued network interface between one cpu core and its cardinal_ring node port.

---
 rtl/cardinal_defs.sv | 18 +
 rtl/cardinal_fifo.sv | 47 ++++
 rtl/cardinal_nic_fifo.sv | 100 ++++++++++
 3 files changed

// File: rtl/cardinal_defs.sv
// Shared definitions for the cardinal ring NIC: packet width, VC bit position
// and the CPU-visible register map.
package cardinal_defs;

    localparam int DATA_WIDTH = 64;
    localparam int NIC_DEPTH  = 4;

    // Bit 0 in MSB-first [0:N-1] numbering carries the virtual channel.
    localparam int VC_BIT = 0;

    typedef enum logic [1:0] {
        ADDR_IN_BUF  = 2'b00,
        ADDR_IN_STS  = 2'b01,
        ADDR_OUT_BUF = 2'b10,
        ADDR_OUT_STS = 2'b11
    } nic_addr_e;

endpackage

// File: rtl/cardinal_fifo.sv
// Circular FIFO with (PTR_W+1)-bit pointers; the extra wrap bit tells full from empty.
// rdata is the head entry, combinationally, and is only meaningful when !empty.
module cardinal_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [0:DATA_WIDTH-1] wdata,
    output logic [0:DATA_WIDTH-1] rdata,
    output logic                  full,
    output logic                  empty
);

    logic [PTR_W:0]        wptr;
    logic [PTR_W:0]        rptr;
    logic [0:DATA_WIDTH-1] mem [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                   (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
    assign rdata = mem[rptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (PTR_W+1)'(1);
            if (do_pop)  rptr <= rptr + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/cardinal_nic_fifo.sv
// Queued NIC between a CPU core and its cardinal_ring node port: a ring->CPU
// input FIFO and a CPU->ring output FIFO, with polarity-gated injection.
module cardinal_nic_fifo #(
    parameter int DATA_WIDTH = cardinal_defs::DATA_WIDTH,
    parameter int DEPTH      = cardinal_defs::NIC_DEPTH,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:1]            addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicEnWr,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    import cardinal_defs::*;

    logic                  cpu_rd;
    logic                  cpu_wr;
    logic                  in_push;
    logic                  in_pop;
    logic [0:DATA_WIDTH-1] in_head;
    logic                  in_full;
    logic                  in_empty;
    logic                  out_push;
    logic                  out_pop;
    logic [0:DATA_WIDTH-1] out_head;
    logic                  out_full;
    logic                  out_empty;
    nic_addr_e             reg_sel;

    assign reg_sel = nic_addr_e'(addr);
    assign cpu_rd  = nicEn && !nicEnWr;
    assign cpu_wr  = nicEn && nicEnWr;

    // Ring handshakes: a transfer happens on a posedge only when both sides
    // agree in that cycle (net_si && net_ri inbound, net_so && net_ro outbound);
    // neither side may assume a transfer on its own signal alone.
    assign net_ri  = reset && !in_full;
    assign in_push = net_si && net_ri;
    assign in_pop  = cpu_rd && (reg_sel == ADDR_IN_BUF) && !in_empty;

    assign out_push = cpu_wr && (reg_sel == ADDR_OUT_BUF) && !out_full;
    assign net_so   = reset && !out_empty && net_ro &&
                      (out_head[VC_BIT] == net_polarity);
    assign out_pop  = net_so;
    assign net_do   = out_empty ? '0 : out_head;

    cardinal_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) in_q (
        .clk   (clk),
        .reset (reset),
        .push  (in_push),
        .pop   (in_pop),
        .wdata (net_di),
        .rdata (in_head),
        .full  (in_full),
        .empty (in_empty)
    );

    cardinal_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) out_q (
        .clk   (clk),
        .reset (reset),
        .push  (out_push),
        .pop   (out_pop),
        .wdata (d_in),
        .rdata (out_head),
        .full  (out_full),
        .empty (out_empty)
    );

    // Status flags sit in the last bit, which is the numeric LSB under [0:N-1].
    always_comb begin
        d_out = '0;
        if (reset && cpu_rd) begin
            case (reg_sel)
                ADDR_IN_BUF:  if (!in_empty) d_out = in_head;
                ADDR_IN_STS:  d_out[DATA_WIDTH-1] = !in_empty;
                ADDR_OUT_STS: d_out[DATA_WIDTH-1] = out_full;
                default:      d_out = '0;
            endcase
        end
    end

endmodule
